reduce_sum_n: RTL and testbench
===============================

Name: reduce_sum_n

Overview:
- Parametrised successor of the fixed four-operand 16-bit sum co-processor operation.
- Reduces NUM_OPERANDS operands of WIDTH bits to one WIDTH-bit result, one operand per cycle, through a single internal accumulator.
- Supports four run-time modes: unsigned wrap, signed saturate, unsigned saturate, signed max.
- Uses the codebase STB/BUSY handshake on both sides and sits between the PCPI decode stage and the result writeback module.

Parameters:
WIDTH, 16, operand and result width in bits (>=4)
NUM_OPERANDS, 4, operand count per operation (>=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
input_operands  input  NUM_OPERANDS*WIDTH  operand i at bits [i*WIDTH +: WIDTH]
input_mode  input  2  00 unsigned wrap, 01 signed saturate, 10 unsigned saturate, 11 signed max
red_input_STB  input  1  upstream strobe: operands and mode valid
red_BUSY  output  1  block busy; input accepted only while low
output_result  output  WIDTH  reduced result
output_overflow  output  1  true result not representable (modes 00/01/10); always 0 in mode 11
red_output_STB  output  1  result valid
output_module_BUSY  input  1  downstream busy; transfer when red_output_STB && !output_module_BUSY

Behaviour:
- Reset (rst low, asynchronous, any state):
  - red_BUSY=0, red_output_STB=0, output_result=0, output_overflow=0.
  - State returns to IDLE; any in-flight operation is discarded and no output strobe is produced.
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - Accept occurs on an edge where red_input_STB=1 and red_BUSY=0.
  - At accept, all operands and the mode are registered. Later input changes have no effect.
  - At accept: acc <= operand0 (zero-extended for modes 00/10, sign-extended for 01/11); idx <= 1; red_BUSY <= 1; next state ACCUM.
- ACCUM:
  - Each edge processes operand[idx] and increments idx.
  - Modes 00/01/10 add into acc. acc is WIDTH+clog2(NUM_OPERANDS)+1 bits wide, so no intermediate overflow occurs.
  - Mode 11: acc <= signed max(acc, operand[idx]).
  - On the edge that processes idx == NUM_OPERANDS-1:
    - Register output_result and output_overflow from the final acc.
    - red_output_STB <= 1; next state OUTPUT.
  - Latency: red_output_STB is high NUM_OPERANDS-1 edges after the accept edge.
- Final result rules:
  - 00: low WIDTH bits of acc; overflow = acc > 2^WIDTH-1.
  - 01: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; overflow = clamp occurred.
  - 10: clamp to 2^WIDTH-1; overflow = clamp occurred.
  - 11: low WIDTH bits of acc; overflow = 0.
- OUTPUT:
  - output_result, output_overflow and red_output_STB stay stable while output_module_BUSY=1, for any number of cycles.
  - On an edge with output_module_BUSY=0: red_output_STB <= 0, red_BUSY <= 0, next state IDLE.
- red_BUSY is high from the accept edge up to the transfer edge.
  - red_input_STB while busy is ignored, with no queuing.
  - The earliest next accept is the edge after the transfer edge.
- output_result and output_overflow hold their last values in IDLE until the next result is registered.
- input_mode and operand changes mid-operation have no effect.
- Out-of-range parameters (WIDTH<4, NUM_OPERANDS<2) must trigger an elaboration-time error.

Test Plan:
1. Mode 00, operands 1,2,3,4, output_module_BUSY=0 -> output_result=10, overflow=0, red_output_STB high exactly 3 edges after accept and for 1 cycle, red_BUSY high for 4 cycles.
2. Mode 00, operands 0xFFFF,0x0001,0,0 -> result 0x0000, overflow=1. Mode 10 with the same operands -> result 0xFFFF, overflow=1.
3. Mode 01, operands 0x7000,0x7000,0x1000,0 -> 0x7FFF, overflow=1. Operands 0x8000,0xFFFF,0,0 -> 0x8000, overflow=1. Operands 0x0005,0xFFFE,0,0 -> 0x0003, overflow=0.
4. Mode 11, operands 0xFFFF,0x0003,0x8000,0x0002 -> 0x0003, overflow=0. Rebuild with NUM_OPERANDS=8 and operands 1..8 in mode 00 -> result 36, latency 7 edges.
5. Backpressure: hold output_module_BUSY=1 for 10 cycles after STB rises -> STB and result stable; a second red_input_STB pulse with different operands is ignored. Release -> STB and red_BUSY fall on the next edge, a new input is accepted on the following edge, and its result is correct.
6. Drive rst low mid-ACCUM, asynchronous to clk -> all outputs 0 immediately, no STB after release. The next operation (1,1,1,1, mode 00) returns 4.

Source files
------------

// File: rtl/reduce_sum_n.sv
// Sequential N-operand reduction: one operand per cycle into a widened accumulator, then a
// mode-dependent wrap/saturate/max finalisation. STB/BUSY handshake on both sides.
module reduce_sum_n #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned NUM_OPERANDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_OPERANDS*WIDTH-1:0] input_operands,
    input  logic [1:0]                    input_mode,
    input  logic                          red_input_STB,
    output logic                          red_BUSY,
    output logic [WIDTH-1:0]              output_result,
    output logic                          output_overflow,
    output logic                          red_output_STB,
    input  logic                          output_module_BUSY
);

    if (WIDTH < 4 || NUM_OPERANDS < 2) begin : gen_param_check
        $error("reduce_sum_n: WIDTH must be >= 4 and NUM_OPERANDS >= 2");
    end

    localparam int unsigned IdxW = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1;
    // One spare bit above the worst-case sum so signed and unsigned sums never wrap.
    localparam int unsigned AccW = WIDTH + $clog2(NUM_OPERANDS) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_OPERANDS - 1);

    typedef enum logic [1:0] {
        ModeWrap = 2'b00,
        ModeSSat = 2'b01,
        ModeUSat = 2'b10,
        ModeSMax = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StOutput
    } state_e;

    state_e                        state_q;
    mode_e                         mode_q;
    logic [NUM_OPERANDS*WIDTH-1:0] ops_q;
    logic [AccW-1:0]               acc_q;
    logic [IdxW-1:0]               idx_q;

    logic [WIDTH-1:0] cur_op;
    logic [AccW-1:0]  cur_ext;
    logic [AccW-1:0]  acc_d;
    logic [WIDTH-1:0] fin_result;
    logic             fin_overflow;
    logic             unsigned_hi;
    logic             signed_fits;

    // Signed modes (01, 11) have mode bit 0 set.
    function automatic logic [AccW-1:0] extend(input logic [WIDTH-1:0] op, input logic sgn);
        return {{(AccW-WIDTH){sgn & op[WIDTH-1]}}, op};
    endfunction

    always_comb begin
        cur_op  = ops_q[idx_q*WIDTH +: WIDTH];
        cur_ext = extend(cur_op, mode_q[0]);
        if (mode_q == ModeSMax) begin
            acc_d = ($signed(cur_ext) > $signed(acc_q)) ? cur_ext : acc_q;
        end else begin
            acc_d = acc_q + cur_ext;
        end

        unsigned_hi = |acc_d[AccW-1:WIDTH];
        // Representable as signed WIDTH iff all bits from the WIDTH-1 sign position up agree.
        signed_fits = (&acc_d[AccW-1:WIDTH-1]) || ~(|acc_d[AccW-1:WIDTH-1]);

        fin_result   = acc_d[WIDTH-1:0];
        fin_overflow = 1'b0;
        unique case (mode_q)
            ModeWrap: fin_overflow = unsigned_hi;
            ModeSSat: begin
                fin_overflow = ~signed_fits;
                if (!signed_fits) begin
                    fin_result = acc_d[AccW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            ModeUSat: begin
                fin_overflow = unsigned_hi;
                if (unsigned_hi) fin_result = {WIDTH{1'b1}};
            end
            ModeSMax: fin_overflow = 1'b0;
            default:  fin_overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            mode_q          <= ModeWrap;
            ops_q           <= '0;
            acc_q           <= '0;
            idx_q           <= '0;
            red_BUSY        <= 1'b0;
            output_result   <= '0;
            output_overflow <= 1'b0;
            red_output_STB  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (red_input_STB && !red_BUSY) begin
                        ops_q    <= input_operands;
                        mode_q   <= mode_e'(input_mode);
                        acc_q    <= extend(input_operands[WIDTH-1:0], input_mode[0]);
                        idx_q    <= IdxW'(1);
                        red_BUSY <= 1'b1;
                        state_q  <= StAccum;
                    end
                end
                StAccum: begin
                    acc_q <= acc_d;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        output_result   <= fin_result;
                        output_overflow <= fin_overflow;
                        red_output_STB  <= 1'b1;
                        state_q         <= StOutput;
                    end
                end
                StOutput: begin
                    if (!output_module_BUSY) begin
                        red_output_STB <= 1'b0;
                        red_BUSY       <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_reduce_sum_n.sv
// Scoreboard bench for reduce_sum_n: directed vectors push expected results, monitors pop on
// each output transfer. Covers a 4-operand and an 8-operand instance.
module tb_reduce_sum_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] input_operands;
    logic [1:0]  input_mode;
    logic        red_input_STB;
    logic        red_BUSY;
    logic [15:0] output_result;
    logic        output_overflow;
    logic        red_output_STB;
    logic        output_module_BUSY;

    logic [127:0] d8_ops;
    logic [1:0]   d8_mode;
    logic         d8_stb_in;
    logic         d8_busy;
    logic [15:0]  d8_result;
    logic         d8_ovf;
    logic         d8_stb;
    logic         d8_obusy;

    reduce_sum_n #(.WIDTH(16), .NUM_OPERANDS(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .input_operands     (input_operands),
        .input_mode         (input_mode),
        .red_input_STB      (red_input_STB),
        .red_BUSY           (red_BUSY),
        .output_result      (output_result),
        .output_overflow    (output_overflow),
        .red_output_STB     (red_output_STB),
        .output_module_BUSY (output_module_BUSY)
    );

    reduce_sum_n #(.WIDTH(16), .NUM_OPERANDS(8)) dut8 (
        .clk                (clk),
        .rst                (rst),
        .input_operands     (d8_ops),
        .input_mode         (d8_mode),
        .red_input_STB      (d8_stb_in),
        .red_BUSY           (d8_busy),
        .output_result      (d8_result),
        .output_overflow    (d8_ovf),
        .red_output_STB     (d8_stb),
        .output_module_BUSY (d8_obusy)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [16:0] exp_q[$];
    logic [16:0] exp8_q[$];
    logic [16:0] e4;
    logic [16:0] e8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // Monitors: a result is consumed on any edge where STB is high and downstream is free.
    always @(negedge clk) begin
        if (rst && red_output_STB && !output_module_BUSY) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got %0h/%0b, required no strobe",
                         output_result, output_overflow);
            end else begin
                e4 = exp_q.pop_front();
                check("result", 32'(output_result), 32'(e4[15:0]));
                check("overflow", 32'(output_overflow), 32'(e4[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && d8_stb && !d8_obusy) begin
            if (exp8_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result8: got %0h, required no strobe", d8_result);
            end else begin
                e8 = exp8_q.pop_front();
                check("result8", 32'(d8_result), 32'(e8[15:0]));
                check("overflow8", 32'(d8_ovf), 32'(e8[16]));
            end
        end
    end

    // Called at posedge+1. Returns at posedge+1 with STB high (or, when downstream is free,
    // one edge later after the transfer has completed).
    task automatic send(input logic [63:0] ops, input logic [1:0] mode, input logic [15:0] er,
                        input logic eo, input string tag);
        int n;
        logic busy_ok;
        n = 0;
        while (red_BUSY && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, 32'(red_BUSY), 32'd0);
        input_operands = ops;
        input_mode     = mode;
        red_input_STB  = 1'b1;
        exp_q.push_back({eo, er});
        @(posedge clk); #1;
        red_input_STB  = 1'b0;
        input_operands = {$urandom, $urandom};
        input_mode     = ~mode;
        check({tag, "_busy_at_accept"}, 32'(red_BUSY), 32'd1);
        n = 0;
        busy_ok = 1'b1;
        while (!red_output_STB && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (!red_BUSY) busy_ok = 1'b0;
        end
        check({tag, "_latency"}, 32'(n), 32'd3);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        if (!output_module_BUSY) begin
            @(posedge clk); #1;
            check({tag, "_stb_drop"}, 32'(red_output_STB), 32'd0);
            check({tag, "_busy_drop"}, 32'(red_BUSY), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        logic no_stb;
        int   n;

        rst = 1'b0;
        input_operands = '0; input_mode = 2'b00; red_input_STB = 1'b0; output_module_BUSY = 1'b0;
        d8_ops = '0; d8_mode = 2'b00; d8_stb_in = 1'b0; d8_obusy = 1'b0;
        #12;
        check("rst_busy", 32'(red_BUSY), 32'd0);
        check("rst_stb", 32'(red_output_STB), 32'd0);
        check("rst_result", 32'(output_result), 32'd0);
        check("rst_ovf", 32'(output_overflow), 32'd0);
        check("rst_stb8", 32'(d8_stb), 32'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;

        send(pack4(16'd1, 16'd2, 16'd3, 16'd4), 2'b00, 16'd10, 1'b0, "t1");
        send(pack4(16'hFFFF, 16'h0001, 16'h0, 16'h0), 2'b00, 16'h0000, 1'b1, "t2_wrap");
        send(pack4(16'hFFFF, 16'h0001, 16'h0, 16'h0), 2'b10, 16'hFFFF, 1'b1, "t2_usat");
        send(pack4(16'h7000, 16'h7000, 16'h1000, 16'h0), 2'b01, 16'h7FFF, 1'b1, "t3_pos");
        send(pack4(16'h8000, 16'hFFFF, 16'h0, 16'h0), 2'b01, 16'h8000, 1'b1, "t3_neg");
        send(pack4(16'h0005, 16'hFFFE, 16'h0, 16'h0), 2'b01, 16'h0003, 1'b0, "t3_fit");
        send(pack4(16'hFFFF, 16'h0003, 16'h8000, 16'h0002), 2'b11, 16'h0003, 1'b0, "t4_max");

        // Backpressure: hold downstream busy, pulse a second request that must be dropped.
        output_module_BUSY = 1'b1;
        send(pack4(16'd10, 16'd20, 16'd30, 16'd40), 2'b00, 16'd100, 1'b0, "t5");
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                input_operands = pack4(16'd5, 16'd5, 16'd5, 16'd5);
                input_mode     = 2'b00;
                red_input_STB  = 1'b1;
            end else begin
                red_input_STB = 1'b0;
            end
            @(posedge clk); #1;
            if (!red_output_STB || output_result != 16'd100 || !red_BUSY) stable = 1'b0;
        end
        red_input_STB = 1'b0;
        check("t5_stable", 32'(stable), 32'd1);
        output_module_BUSY = 1'b0;
        @(posedge clk); #1;
        check("t5_stb_release", 32'(red_output_STB), 32'd0);
        check("t5_busy_release", 32'(red_BUSY), 32'd0);
        send(pack4(16'hFFFF, 16'hFFFF, 16'h0, 16'h0), 2'b10, 16'hFFFF, 1'b1, "t5_next");

        // Asynchronous reset in the middle of accumulation.
        input_operands = pack4(16'd7, 16'd7, 16'd7, 16'd7);
        input_mode     = 2'b00;
        red_input_STB  = 1'b1;
        @(posedge clk); #1;
        red_input_STB  = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_busy", 32'(red_BUSY), 32'd0);
        check("t6_stb", 32'(red_output_STB), 32'd0);
        check("t6_result", 32'(output_result), 32'd0);
        check("t6_ovf", 32'(output_overflow), 32'd0);
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        no_stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (red_output_STB || red_BUSY) no_stb = 1'b0;
        end
        check("t6_no_stb", 32'(no_stb), 32'd1);
        send(pack4(16'd1, 16'd1, 16'd1, 16'd1), 2'b00, 16'd4, 1'b0, "t6_after");

        // Eight-operand instance: 1..8 summed, seven-edge latency.
        for (int i = 0; i < 8; i++) d8_ops[i*16 +: 16] = 16'(i + 1);
        d8_mode   = 2'b00;
        d8_stb_in = 1'b1;
        exp8_q.push_back({1'b0, 16'd36});
        @(posedge clk); #1;
        d8_stb_in = 1'b0;
        d8_ops    = '1;
        check("t4_busy8", 32'(d8_busy), 32'd1);
        n = 0;
        while (!d8_stb && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_latency8", 32'(n), 32'd7);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("sb8_drain", 32'(exp8_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
